mcpu_core_scoreboard: RTL

- Register-hazard scoreboard sitting between decode and the 4-lane, 8-read/4-write register file.
- Tracks GPRs with in-flight writes from long-latency ops: unbounded loads, and fixed-latency multiply/divide.
- Stalls issue of a 4-lane bundle whose sources (RAW) or destinations (WAW) are pending.
- Keeps a bounded count of outstanding unbounded ops.

---
 rtl/mcpu_core_scoreboard_if.sv | 58 +++++
 rtl/mcpu_core_scoreboard.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mcpu_core_scoreboard_if.sv
// Decode/writeback <-> register-hazard scoreboard signal bundle.
// Predicate tracking signals exist only when MCPU_SB_PRED_TRACK_EN is defined.
interface mcpu_core_scoreboard_if;
    logic        d2sb_issue;
    logic [3:0]  d2sb_lane_valid;
    logic [19:0] d2sb_rs_num;
    logic [3:0]  d2sb_rs_use;
    logic [19:0] d2sb_rt_num;
    logic [3:0]  d2sb_rt_use;
    logic [19:0] d2sb_rd_num;
    logic [3:0]  d2sb_rd_long;
    logic [3:0]  d2sb_rd_fixed;
    logic [3:0]  d2sb_rd_we;
    logic        wb2sb_done_valid;
    logic [4:0]  wb2sb_done_num;
    logic        sb2d_stall;
    logic [5:0]  sb_long_cnt;
    logic [31:0] sb_pending;
    logic        sb_err;
`ifdef MCPU_SB_PRED_TRACK_EN
    logic [3:0]  d2sb_pred_use;
    logic [7:0]  d2sb_pred_num;
    logic [3:0]  d2sb_pred_long;
    logic        wb2sb_pred_done_valid;
    logic [1:0]  wb2sb_pred_done_num;
    logic [2:0]  sb_pred_pending;

    modport master (
        output d2sb_issue, d2sb_lane_valid, d2sb_rs_num, d2sb_rs_use, d2sb_rt_num,
               d2sb_rt_use, d2sb_rd_num, d2sb_rd_long, d2sb_rd_fixed, d2sb_rd_we,
               wb2sb_done_valid, wb2sb_done_num,
               d2sb_pred_use, d2sb_pred_num, d2sb_pred_long,
               wb2sb_pred_done_valid, wb2sb_pred_done_num,
        input  sb2d_stall, sb_long_cnt, sb_pending, sb_err, sb_pred_pending
    );
    modport slave (
        input  d2sb_issue, d2sb_lane_valid, d2sb_rs_num, d2sb_rs_use, d2sb_rt_num,
               d2sb_rt_use, d2sb_rd_num, d2sb_rd_long, d2sb_rd_fixed, d2sb_rd_we,
               wb2sb_done_valid, wb2sb_done_num,
               d2sb_pred_use, d2sb_pred_num, d2sb_pred_long,
               wb2sb_pred_done_valid, wb2sb_pred_done_num,
        output sb2d_stall, sb_long_cnt, sb_pending, sb_err, sb_pred_pending
    );
`else
    modport master (
        output d2sb_issue, d2sb_lane_valid, d2sb_rs_num, d2sb_rs_use, d2sb_rt_num,
               d2sb_rt_use, d2sb_rd_num, d2sb_rd_long, d2sb_rd_fixed, d2sb_rd_we,
               wb2sb_done_valid, wb2sb_done_num,
        input  sb2d_stall, sb_long_cnt, sb_pending, sb_err
    );
    modport slave (
        input  d2sb_issue, d2sb_lane_valid, d2sb_rs_num, d2sb_rs_use, d2sb_rt_num,
               d2sb_rt_use, d2sb_rd_num, d2sb_rd_long, d2sb_rd_fixed, d2sb_rd_we,
               wb2sb_done_valid, wb2sb_done_num,
        output sb2d_stall, sb_long_cnt, sb_pending, sb_err
    );
`endif
endinterface

// File: rtl/mcpu_core_scoreboard.sv
// Register-hazard scoreboard for 4-lane issue: tracks long (load) and fixed-latency GPR writes.
// Optional predicate tracking (p0..p2) is enabled by defining MCPU_SB_PRED_TRACK_EN.
module mcpu_core_scoreboard #(
    parameter int FIX_LAT  = 3,
    parameter int MAX_LONG = 8
) (
    input logic                   clkrst_core_clk,
    input logic                   clkrst_core_rst,
    mcpu_core_scoreboard_if.slave sb
);
    localparam logic [2:0] FIX_INIT   = 3'(FIX_LAT);
    localparam logic [6:0] MAX_LONG_W = 7'(MAX_LONG);

    // Handshake: decode holds d2sb_issue and the bundle; it issues on any cycle where
    // d2sb_issue=1 and sb2d_stall=0 (fire). sb2d_stall is combinational and never
    // asserts without d2sb_issue. wb2sb_done_valid is a single-cycle strobe, no backpressure.

    logic [31:0] long_pend, long_pend_nxt;
    logic [2:0]  fix_cnt [32];
    logic [5:0]  long_cnt, long_cnt_nxt;
    logic        err, err_nxt;
    logic [31:0] fix_nz, pend;
    logic        hazard, overflow, stall, fire;
    logic [2:0]  n_req;
    logic [31:0] set_long, set_fix;
    logic        dual_err;
    logic [5:0]  n_new;
    logic        done_dec, done_err;
    logic        pred_hazard, pred_err;

    always_comb begin
        for (int r = 0; r < 32; r++) fix_nz[r] = (fix_cnt[r] != 3'd0);
    end

    assign pend = long_pend | fix_nz;

    always_comb begin
        hazard = 1'b0;
        n_req  = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (sb.d2sb_lane_valid[i]) begin
                if (sb.d2sb_rs_use[i] && pend[sb.d2sb_rs_num[5*i +: 5]]) hazard = 1'b1;
                if (sb.d2sb_rt_use[i] && pend[sb.d2sb_rt_num[5*i +: 5]]) hazard = 1'b1;
                if (sb.d2sb_rd_we[i]  && pend[sb.d2sb_rd_num[5*i +: 5]]) hazard = 1'b1;
                if (sb.d2sb_rd_long[i]) n_req = n_req + 3'd1;
            end
        end
        overflow = ({1'b0, long_cnt} + {4'd0, n_req}) > MAX_LONG_W;
    end

    assign stall = sb.d2sb_issue & (hazard | overflow | pred_hazard);
    assign fire  = sb.d2sb_issue & ~stall;

    // Walk lanes high to low so the lower-numbered lane's kind overrides on a shared rd.
    always_comb begin
        set_long = '0;
        set_fix  = '0;
        dual_err = 1'b0;
        if (fire) begin
            for (int i = 3; i >= 0; i--) begin
                if (sb.d2sb_lane_valid[i]) begin
                    if (sb.d2sb_rd_long[i]) begin
                        set_long[sb.d2sb_rd_num[5*i +: 5]] = 1'b1;
                        set_fix[sb.d2sb_rd_num[5*i +: 5]]  = 1'b0;
                    end else if (sb.d2sb_rd_fixed[i]) begin
                        set_fix[sb.d2sb_rd_num[5*i +: 5]]  = 1'b1;
                        set_long[sb.d2sb_rd_num[5*i +: 5]] = 1'b0;
                    end
                    if (sb.d2sb_rd_long[i] && sb.d2sb_rd_fixed[i]) dual_err = 1'b1;
                end
            end
        end
    end

    // Count registers, not lanes, so long_cnt tracks the number of set long_pend bits.
    always_comb begin
        n_new = '0;
        for (int r = 0; r < 32; r++) n_new = n_new + 6'(set_long[r] & ~long_pend[r]);
    end

    always_comb begin
        done_dec      = sb.wb2sb_done_valid & long_pend[sb.wb2sb_done_num]
                        & ~set_long[sb.wb2sb_done_num];
        done_err      = sb.wb2sb_done_valid & (~long_pend[sb.wb2sb_done_num]
                        | set_long[sb.wb2sb_done_num]);
        long_pend_nxt = long_pend;
        if (sb.wb2sb_done_valid) long_pend_nxt[sb.wb2sb_done_num] = 1'b0;
        long_pend_nxt = long_pend_nxt | set_long;
        long_cnt_nxt  = long_cnt + n_new - {5'd0, done_dec};
        err_nxt       = err | dual_err | done_err | pred_err;
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            long_pend <= '0;
            long_cnt  <= '0;
            err       <= 1'b0;
            for (int r = 0; r < 32; r++) fix_cnt[r] <= 3'd0;
        end else begin
            long_pend <= long_pend_nxt;
            long_cnt  <= long_cnt_nxt;
            err       <= err_nxt;
            for (int r = 0; r < 32; r++) begin
                if (set_fix[r])     fix_cnt[r] <= FIX_INIT;
                else if (fix_nz[r]) fix_cnt[r] <= fix_cnt[r] - 3'd1;
            end
        end
    end

`ifdef MCPU_SB_PRED_TRACK_EN
    // Predicates are padded to 4 entries so predicate number 3 indexes a constant-zero slot.
    logic [2:0] pred_pend;
    logic [3:0] pred_pend4, set_pred4, pred_pend_nxt4;
    logic       pred_done_v;

    assign pred_pend4 = {1'b0, pred_pend};

    always_comb begin
        pred_hazard = 1'b0;
        set_pred4   = '0;
        for (int i = 0; i < 4; i++) begin
            if (sb.d2sb_lane_valid[i] && (sb.d2sb_pred_use[i] || sb.d2sb_pred_long[i])
                && pred_pend4[sb.d2sb_pred_num[2*i +: 2]])
                pred_hazard = 1'b1;
            if (fire && sb.d2sb_lane_valid[i] && sb.d2sb_pred_long[i])
                set_pred4[sb.d2sb_pred_num[2*i +: 2]] = 1'b1;
        end
        set_pred4[3] = 1'b0;
        pred_done_v  = sb.wb2sb_pred_done_valid && (sb.wb2sb_pred_done_num != 2'd3);
        pred_err     = pred_done_v & (~pred_pend4[sb.wb2sb_pred_done_num]
                       | set_pred4[sb.wb2sb_pred_done_num]);
        pred_pend_nxt4 = pred_pend4;
        if (pred_done_v) pred_pend_nxt4[sb.wb2sb_pred_done_num] = 1'b0;
        pred_pend_nxt4 = pred_pend_nxt4 | set_pred4;
    end

    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) pred_pend <= '0;
        else                 pred_pend <= pred_pend_nxt4[2:0];
    end

    assign sb.sb_pred_pending = pred_pend;
`else
    assign pred_hazard = 1'b0;
    assign pred_err    = 1'b0;
`endif

    assign sb.sb2d_stall  = stall;
    assign sb.sb_long_cnt = long_cnt;
    assign sb.sb_pending  = pend;
    assign sb.sb_err      = err;
endmodule
